// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial system bus endpoints.
//   state_t      master port FSM states
//   MODE_*       transaction direction encoding (mmode / dmode)
//   DEF_*        default widths and timeout
//   cnt_width()  width of the shared bit counter
// -----------------------------------------------------------------------------
package bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ADDR,
      ST_WDATA,
      ST_RWAIT,
      ST_RDATA,
      ST_DONE
   } state_t;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   localparam int DEF_ADDR_WIDTH     = 12;
   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_TIMEOUT_CYCLES = 256;

   // Counter must index the longer of the address and data phases.
   function automatic int cnt_width(input int aw, input int dw);
      int m;
      m = (aw > dw) ? aw : dw;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/serial_shifter.sv
// -----------------------------------------------------------------------------
// serial_shifter
// Datapath of the master port: one output shift register holding
// {write data, address} shifted out LSB first, one input shift register that
// assembles read data LSB first, and the bit counter shared by all phases.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load, ldata   parallel load of {wdata, addr}
//   shift_en      advance the output register by one bit
//   sout          current serial output bit
//   cap_en, sin   capture one serial input bit
//   pdata         read word including the bit being presented on sin
//   cnt_clr       clear the bit counter (priority over cnt_inc)
//   cnt_inc       increment the bit counter
//   cnt           bit counter value
// DATA_WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module serial_shifter
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_W      = cnt_width(ADDR_WIDTH, DATA_WIDTH)
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] ldata,
   input  logic                           shift_en,
   output logic                           sout,
   input  logic                           cap_en,
   input  logic                           sin,
   output logic [DATA_WIDTH-1:0]          pdata,
   input  logic                           cnt_clr,
   input  logic                           cnt_inc,
   output logic [CNT_W-1:0]               cnt
);

   logic [ADDR_WIDTH+DATA_WIDTH-1:0] osr;
   // Holds the bits captured so far; the newest bit sits at the top so that
   // the finished word is {last bit, isr} with bit 0 arriving first.
   logic [DATA_WIDTH-2:0]            isr;

   assign sout  = osr[0];
   assign pdata = {sin, isr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         osr <= '0;
         isr <= '0;
         cnt <= '0;
      end else begin
         if (load)
            osr <= ldata;
         else if (shift_en)
            osr <= osr >> 1;

         if (cap_en)
            isr <= pdata[DATA_WIDTH-1:1];

         if (cnt_clr)
            cnt <= '0;
         else if (cnt_inc)
            cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/master_port.sv
// -----------------------------------------------------------------------------
// master_port
// Master-side endpoint of the serial system bus. Accepts one parallel
// read/write request from a local device, requests the bus, shifts the
// address (and write data) out LSB first, and for reads deserialises the
// returned data.
// Optional feature: define MASTER_PORT_TIMEOUT_EN to abort a read after
// TIMEOUT_CYCLES clocks without svalid (drdata = all ones).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   dvalid     device request valid        dready   port idle / accepting
//   dmode      1 = write, 0 = read         daddr    request address
//   dwdata     write data                  drdata   read data (holds)
//   drvalid    completion pulse
//   mbreq      bus request                 mbgrant  bus grant
//   mwdata     serial address/write data   mrdata   serial read data
//   mmode      direction while mvalid      mvalid   mwdata bit valid
//   svalid     mrdata bit valid
// -----------------------------------------------------------------------------
module master_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dvalid,
   output logic                  dready,
   input  logic                  dmode,
   input  logic [ADDR_WIDTH-1:0] daddr,
   input  logic [DATA_WIDTH-1:0] dwdata,
   output logic [DATA_WIDTH-1:0] drdata,
   output logic                  drvalid,
   output logic                  mbreq,
   input  logic                  mbgrant,
   output logic                  mwdata,
   input  logic                  mrdata,
   output logic                  mmode,
   output logic                  mvalid,
   input  logic                  svalid
);

   localparam int CNT_W = cnt_width(ADDR_WIDTH, DATA_WIDTH);
   localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_WIDTH - 1);
   // Bit 0 is captured in RWAIT, so RDATA only counts the remaining bits.
   localparam logic [CNT_W-1:0] RDATA_LAST = CNT_W'(DATA_WIDTH - 2);

   state_t            state, nstate;
   logic              mode;
   logic              load, shift_en, cap_en, cnt_inc, cnt_clr;
   logic              rd_upd, rd_ones;
   logic              sout;
   logic [DATA_WIDTH-1:0] pdata;
   logic [CNT_W-1:0]  cnt;
   logic              tmo;

   serial_shifter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_W      (CNT_W)
   ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .ldata    ({dwdata, daddr}),
      .shift_en (shift_en),
      .sout     (sout),
      .cap_en   (cap_en),
      .sin      (mrdata),
      .pdata    (pdata),
      .cnt_clr  (cnt_clr),
      .cnt_inc  (cnt_inc),
      .cnt      (cnt)
   );

`ifdef MASTER_PORT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   logic          waiting;

   assign waiting = (state == ST_RWAIT) || (state == ST_RDATA);
   assign tmo     = waiting && !svalid && (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tcnt <= '0;
      else if (!waiting || svalid)
         tcnt <= '0;
      else
         tcnt <= tcnt + TW'(1);
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         mode   <= MODE_READ;
         drdata <= '0;
      end else begin
         state <= nstate;
         if (load)
            mode <= dmode;
         if (rd_ones)
            drdata <= '1;
         else if (rd_upd)
            drdata <= pdata;
      end
   end

   always_comb begin
      nstate   = state;
      dready   = 1'b0;
      mbreq    = 1'b0;
      mvalid   = 1'b0;
      mmode    = 1'b0;
      drvalid  = 1'b0;
      load     = 1'b0;
      shift_en = 1'b0;
      cap_en   = 1'b0;
      cnt_inc  = 1'b0;
      rd_upd   = 1'b0;
      rd_ones  = 1'b0;

      unique case (state)
         ST_IDLE: begin
            dready = 1'b1;
            if (dvalid) begin
               load   = 1'b1;
               nstate = ST_REQ;
            end
         end
         ST_REQ: begin
            mbreq = 1'b1;
            if (mbgrant)
               nstate = ST_ADDR;
         end
         ST_ADDR: begin
            mbreq    = 1'b1;
            mvalid   = 1'b1;
            mmode    = mode;
            shift_en = 1'b1;
            cnt_inc  = 1'b1;
            if (cnt == ADDR_LAST)
               nstate = (mode == MODE_WRITE) ? ST_WDATA : ST_RWAIT;
         end
         ST_WDATA: begin
            mbreq    = 1'b1;
            mvalid   = 1'b1;
            mmode    = mode;
            shift_en = 1'b1;
            cnt_inc  = 1'b1;
            if (cnt == DATA_LAST)
               nstate = ST_DONE;
         end
         ST_RWAIT: begin
            mbreq = 1'b1;
            if (svalid) begin
               cap_en = 1'b1;
               nstate = ST_RDATA;
            end else if (tmo) begin
               rd_ones = 1'b1;
               nstate  = ST_DONE;
            end
         end
         ST_RDATA: begin
            mbreq = 1'b1;
            if (svalid) begin
               cap_en  = 1'b1;
               cnt_inc = 1'b1;
               if (cnt == RDATA_LAST) begin
                  rd_upd = 1'b1;
                  nstate = ST_DONE;
               end
            end else if (tmo) begin
               rd_ones = 1'b1;
               nstate  = ST_DONE;
            end
         end
         ST_DONE: begin
            drvalid = 1'b1;
            nstate  = ST_IDLE;
         end
         default: nstate = ST_IDLE;
      endcase
   end

   // Bit counter restarts at every phase boundary.
   assign cnt_clr = (nstate != state);
   assign mwdata  = mvalid & sout;

endmodule

// File: tb/tb_master_port.sv
`timescale 1ns/1ps
module tb_master_port;

   localparam int AW  = 12;
   localparam int DW  = 8;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dvalid = 1'b0;
   logic          dmode = 1'b0;
   logic [AW-1:0] daddr = '0;
   logic [DW-1:0] dwdata = '0;
   logic          mbgrant = 1'b0;
   logic          mrdata = 1'b0;
   logic          svalid = 1'b0;
   logic          dready, drvalid, mbreq, mwdata, mmode, mvalid;
   logic [DW-1:0] drdata;

   master_port #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .dvalid  (dvalid),
      .dready  (dready),
      .dmode   (dmode),
      .daddr   (daddr),
      .dwdata  (dwdata),
      .drdata  (drdata),
      .drvalid (drvalid),
      .mbreq   (mbreq),
      .mbgrant (mbgrant),
      .mwdata  (mwdata),
      .mrdata  (mrdata),
      .mmode   (mmode),
      .mvalid  (mvalid),
      .svalid  (svalid)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   // Model: serial bit stream the bus must carry, and the drdata value
   // expected at each completion pulse.
   bit            exp_bits[$];
   logic [DW-1:0] exp_done[$];
   logic          exp_mode = 1'b0;
   logic [DW-1:0] model_rd = '0;

   bit log_bits[$];
   int run = 0;
   int last_run = 0;
   int pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_txn(input logic m, input logic [AW-1:0] a,
                             input logic [DW-1:0] w, input logic [DW-1:0] r);
      for (int i = 0; i < AW; i++) exp_bits.push_back(a[i]);
      if (m) begin
         for (int i = 0; i < DW; i++) exp_bits.push_back(w[i]);
         exp_done.push_back(model_rd);
      end else begin
         exp_done.push_back(r);
         model_rd = r;
      end
      exp_mode = m;
   endtask

   // Compare process: every cycle, outputs against the model.
   always @(negedge clk) begin
      if (!rst) begin
         if (mvalid) begin
            run++;
            log_bits.push_back(mwdata);
            check("mvalid_expected", (exp_bits.size() != 0), 1);
            if (exp_bits.size() != 0) begin
               check("mwdata", mwdata, exp_bits.pop_front());
               check("mmode", mmode, exp_mode);
            end
         end else if (run != 0) begin
            last_run = run;
            run = 0;
         end
         if (drvalid) begin
            pulses++;
            check("mbreq_in_done", mbreq, 0);
            check("drvalid_expected", (exp_done.size() != 0), 1);
            if (exp_done.size() != 0)
               check("drdata", drdata, exp_done.pop_front());
         end
      end
   end

   task automatic wait_dready();
      int n = 0;
      while (dready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      check("dready_wait", dready, 1);
   endtask

   task automatic accept(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] w);
      dvalid = 1'b1; dmode = m; daddr = a; dwdata = w;
      wait_dready();
      @(negedge clk);
   endtask

   task automatic grant(input int dly);
      int n = 0;
      while (mbreq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      check("mbreq_raised", mbreq, 1);
      repeat (dly) @(negedge clk);
      mbgrant = 1'b1;
   endtask

   task automatic wait_mvalid(input logic lvl, input string name);
      int n = 0;
      while (mvalid !== lvl && n < 200) begin @(negedge clk); n++; end
      check(name, mvalid, lvl);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (drvalid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      check("drvalid_seen", drvalid, 1);
      mbgrant = 1'b0;
      @(negedge clk);
      check("dready_after_done", dready, 1);
   endtask

   task automatic slave(input logic [DW-1:0] r, input int dly,
                        input logic [DW-1:0] gaps, input bit noise);
      wait_mvalid(1'b1, "addr_start");
      if (noise) begin svalid = 1'b1; mrdata = 1'b1; end
      wait_mvalid(1'b0, "addr_end");
      svalid = 1'b0; mrdata = 1'b0;
      repeat (dly) @(negedge clk);
      for (int i = 0; i < DW; i++) begin
         if (gaps[i]) repeat (2) @(negedge clk);
         svalid = 1'b1; mrdata = r[i];
         @(negedge clk);
         svalid = 1'b0; mrdata = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int p0;
      logic [AW+DW-1:0] got;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_dready", dready, 1);
      check("rst_mvalid", mvalid, 0);
      check("rst_mbreq", mbreq, 0);
      check("rst_drvalid", drvalid, 0);
      check("rst_drdata", drdata, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: write A5C / 3C, grant after 3 cycles
      log_bits.delete();
      expect_txn(1'b1, 12'hA5C, 8'h3C, 8'h00);
      accept(1'b1, 12'hA5C, 8'h3C);
      dvalid = 1'b0;
      grant(3);
      wait_done(n);
      check("wr_latency", n, 21);
      check("wr_mvalid_run", last_run, 20);
      got = '0;
      for (int i = 0; i < AW + DW; i++)
         if (i < log_bits.size()) got[i] = log_bits[i];
      check("wr_serial_lit", got, 20'h3CA5C);

      // 2: read 001, slave answers 81 after 5 cycles, svalid noise during ADDR
      expect_txn(1'b0, 12'h001, 8'h00, 8'h81);
      accept(1'b0, 12'h001, 8'h00);
      dvalid = 1'b0;
      grant(1);
      slave(8'h81, 5, 8'h00, 1'b1);
      wait_done(n);
      check("rd_addr_run", last_run, 12);
      check("rd_drdata_lit", drdata, 8'h81);

      // 3: read with gaps before bits 2 and 5
      p0 = pulses;
      expect_txn(1'b0, 12'h7F3, 8'h00, 8'h6B);
      accept(1'b0, 12'h7F3, 8'h00);
      dvalid = 1'b0;
      grant(0);
      slave(8'h6B, 2, 8'b0010_0100, 1'b0);
      wait_done(n);
      repeat (3) @(negedge clk);
      check("gap_pulses", pulses - p0, 1);
      check("gap_drdata_lit", drdata, 8'h6B);

      // 4: dvalid held, daddr changing while busy
      expect_txn(1'b1, 12'h123, 8'h55, 8'h00);
      expect_txn(1'b1, 12'h7E1, 8'hA2, 8'h00);
      accept(1'b1, 12'h123, 8'h55);
      daddr = 12'h3FF; dwdata = 8'h0F;
      grant(1);
      n = 0;
      while (drvalid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      check("held_first_done", drvalid, 1);
      daddr = 12'h7E1; dwdata = 8'hA2;
      mbgrant = 1'b0;
      @(negedge clk);
      check("held_idle_gap", dready, 1);
      @(negedge clk);
      dvalid = 1'b0;
      grant(0);
      wait_done(n);
      check("held_queue_empty", exp_bits.size(), 0);

      // 5: reset during ADDR
      expect_txn(1'b1, 12'h5A5, 8'h99, 8'h00);
      accept(1'b1, 12'h5A5, 8'h99);
      dvalid = 1'b0;
      grant(0);
      wait_mvalid(1'b1, "abort_addr_start");
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_dready", dready, 1);
      check("arst_mvalid", mvalid, 0);
      check("arst_mbreq", mbreq, 0);
      check("arst_mwdata", mwdata, 0);
      check("arst_drvalid", drvalid, 0);
      check("arst_drdata", drdata, 0);
      exp_bits.delete();
      exp_done.delete();
      model_rd = '0;
      mbgrant = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      p0 = pulses;
      repeat (5) @(negedge clk);
      check("abort_no_pulse", pulses - p0, 0);
      expect_txn(1'b0, 12'hC3E, 8'h00, 8'hD4);
      accept(1'b0, 12'hC3E, 8'h00);
      dvalid = 1'b0;
      grant(2);
      slave(8'hD4, 0, 8'h00, 1'b0);
      wait_done(n);
      check("post_rst_drdata_lit", drdata, 8'hD4);

`ifdef MASTER_PORT_TIMEOUT_EN
      // 6: read with no response times out
      expect_txn(1'b0, 12'h0F0, 8'h00, 8'hFF);
      accept(1'b0, 12'h0F0, 8'h00);
      dvalid = 1'b0;
      grant(0);
      wait_mvalid(1'b1, "tmo_addr_start");
      wait_mvalid(1'b0, "tmo_addr_end");
      wait_done(n);
      check("tmo_latency", n, 16);
      check("tmo_drdata_lit", drdata, 8'hFF);
`endif

      repeat (3) @(negedge clk);
      check("final_bits_empty", exp_bits.size(), 0);
      check("final_done_empty", exp_done.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
